bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of cycles in REQ+WAIT before abort; range 2..65535; used only when BUS_INIT_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  CPU access request.
REQ-005 Port: req_ready  output  1  initiator idle; a request is accepted on a clock edge where req_valid=1 and req_ready=1.
REQ-006 Port: req_we  input  1  1=store, 0=load.
REQ-007 Port: req_op  input  3  access size: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data, right-aligned.
REQ-010 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port: resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-012 Port: resp_err  output  1  qualifies resp_valid; 1 = misaligned, illegal op or timeout.
REQ-013 Port: address  output  32  bus address.
REQ-014 Port: wdata  output  32  bus write data.
REQ-015 Port: WLEN  output  2  bus size code: 00 read32, 01 write8, 10 write16, 11 write32.
REQ-016 Port: EN_N  output  1  bus request, active-low.
REQ-017 Port: READY  input  1  bus responder ready; 1 = idle or done, 0 = busy.
REQ-018 Port: rdata  input  32  bus read data; valid when READY returns to 1 after a read32.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT and RESP; req_ready=1 only in IDLE.
REQ-020 On acceptance, the initiator SHALL register addr, op, we and wdata, and SHALL check legality first.
REQ-021 Illegal: req_op not in REQ-007 list; LH/LHU/LW/SH/SW with addr[0]=1 -> IDLE->RESP, no bus cycle, resp_err=1, resp_rdata=0.
REQ-022 Legal: IDLE->REQ; address=req_addr; WLEN = 00 for all loads, 01 SB, 10 SH, 11 SW; wdata=req_wdata; EN_N=0, all from the same edge.
REQ-023 In REQ, EN_N SHALL stay 0 until READY is sampled 0; then EN_N=1 and the state SHALL become WAIT on that edge.
REQ-024 In WAIT, on sampling READY=1 the initiator SHALL capture and extend rdata into resp_rdata and enter RESP.
REQ-025 In RESP, resp_valid SHALL be 1 for exactly one cycle; then the state SHALL become IDLE.
REQ-026 address, WLEN and wdata SHALL be held stable from REQ entry through WAIT exit.
REQ-027 In IDLE, WLEN SHALL be 00 and EN_N SHALL be 1.
REQ-028 Load extraction, with b = addr[0] ? rdata[15:8] : rdata[7:0]: LB = sign-extended b; LBU = zero-extended b; LH = sign-extended rdata[15:0]; LHU = zero-extended rdata[15:0]; LW = rdata.
REQ-029 A store SHALL complete with resp_rdata=0 and resp_err=0.
REQ-030 A new request SHALL NOT be accepted in the RESP cycle; the earliest next acceptance is the cycle after RESP.
REQ-031 Successive bus cycles SHALL be separated by at least one cycle with EN_N=1.

Reset
REQ-032 While reset_n=0, outputs SHALL be: state IDLE, EN_N=1, WLEN=00, address=0, wdata=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, timeout counter=0.
REQ-033 Reset mid-transaction SHALL abort immediately with no response pulse; an in-flight responder cycle is left to finish on its own.

Configuration
REQ-034 Macro BUS_INIT_TIMEOUT_EN defined: a 16-bit counter SHALL clear on REQ entry and count each cycle in REQ or WAIT. On reaching TIMEOUT_CYCLES: EN_N=1, then RESP with resp_err=1 and resp_rdata=0.
REQ-035 Macro BUS_INIT_TIMEOUT_EN undefined: there SHALL be no counter, and REQ/WAIT SHALL wait indefinitely.

Verification
REQ-036 LW addr 0x100, responder model returns 0xDEADBEEF -> one EN_N low pulse, WLEN=00, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-037 LB addr 0x101 with rdata=0x000080FF -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x100 -> 0x000080FF.
REQ-038 SB addr 0x80000 with wdata 0x12345678 -> WLEN=01, wdata=0x12345678 held until READY=1, resp_err=0.
REQ-039 SW addr 0x103 -> EN_N never asserted, resp_valid one cycle after acceptance, resp_err=1.
REQ-040 Responder holds READY=1 forever, TIMEOUT_CYCLES=8, macro defined -> resp_err=1 after 8 cycles in REQ; macro undefined -> req_ready stays 0.
REQ-041 reset_n low while in WAIT -> EN_N=1 and req_ready=1 asynchronously, no resp_valid; the next LW completes normally.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: CPU load/store to READY/EN_N bus initiator; define BUS_INIT_TIMEOUT_EN to abort stalled bus cycles
module bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic [31:0] wdata,
   output logic [1:0]  WLEN,
   output logic        EN_N,
   input  logic        READY,
   input  logic [31:0] rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  wlen_q, wlen_d;
   logic        we_q, we_d, en_n_q, en_n_d, err_q, err_d;
   logic        legal, timeout;
   logic [7:0]  byte_sel;
   logic [31:0] ld_data;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("bus_initiator: TIMEOUT_CYCLES must be 2..65535");
   end

   // byte/half accesses only need addr[0] clear when wider than a byte
   assign legal = (req_we ? req_op inside {3'b000, 3'b001, 3'b010}
                          : req_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                  && !(req_addr[0] && req_op[1:0] != 2'b00);
   assign byte_sel = addr_q[0] ? rdata[15:8] : rdata[7:0];
   assign ld_data  = op_q == 3'b000 ? {{24{byte_sel[7]}}, byte_sel}
                   : op_q == 3'b100 ? {24'd0, byte_sel}
                   : op_q == 3'b001 ? {{16{rdata[15]}}, rdata[15:0]}
                   : op_q == 3'b101 ? {16'd0, rdata[15:0]} : rdata;

`ifdef BUS_INIT_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   assign cnt_d   = state_q == IDLE ? 16'd0 : (state_q == REQ || state_q == WAIT) ? cnt_q + 16'd1 : cnt_q;
   assign timeout = cnt_q >= 16'(TIMEOUT_CYCLES - 1);
   // cycle counter for REQ/WAIT, restarted whenever the initiator is idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // state and bus/response registers; reset returns the bus to its idle levels
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         op_q    <= '0;
         we_q    <= 1'b0;
         wlen_q  <= 2'b00;
         en_n_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         op_q    <= op_d;
         we_q    <= we_d;
         wlen_q  <= wlen_d;
         en_n_q  <= en_n_d;
         err_q   <= err_d;
      end
   end

   // next state: accept, drive the bus handshake, capture the load result or abort
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      op_d    = op_q;
      we_d    = we_q;
      wlen_d  = wlen_q;
      en_n_d  = en_n_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            op_d    = req_op;
            we_d    = req_we;
            state_d = legal ? REQ : RESP;
            en_n_d  = !legal;
            err_d   = !legal;
            rdata_d = '0;
            wlen_d  = (!legal || !req_we) ? 2'b00 : req_op == 3'b000 ? 2'b01 : req_op == 3'b001 ? 2'b10 : 2'b11;
         end
         REQ, WAIT: begin
            if (state_q == REQ && !READY) begin
               en_n_d  = 1'b1;
               state_d = WAIT;
            end else if (state_q == WAIT && READY) begin
               state_d = RESP;
               wlen_d  = 2'b00;
               rdata_d = we_q ? '0 : ld_data;
            end else if (timeout) begin
               state_d = RESP;
               en_n_d  = 1'b1;
               wlen_d  = 2'b00;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            err_d   = 1'b0;
            rdata_d = '0;
         end
      endcase
   end

   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign address    = addr_q;
   assign wdata      = wdata_q;
   assign WLEN       = wlen_q;
   assign EN_N       = en_n_q;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: randomized bench for bus_initiator against a behavioural load/store model and bus responder
module tb_bus_initiator;
   logic        clk = 0, reset_n = 1, req_valid = 0, req_we = 0, READY = 1;
   logic [2:0]  req_op = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, rdata = 0;
   logic        req_ready, resp_valid, resp_err, EN_N;
   logic [31:0] resp_rdata, address, wdata;
   logic [1:0]  WLEN;

   int          n_chk = 0, n_err = 0, bus_cnt = 0, busy_lo = 1, busy_hi = 3;
   bit          hold_ready = 0;
   logic [31:0] rsp_data = 0, seen_addr = 0, seen_wdata = 0;
   logic [1:0]  seen_wlen = 0;

   always #5 clk = ~clk;

   bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .address(address), .wdata(wdata), .WLEN(WLEN), .EN_N(EN_N), .READY(READY), .rdata(rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // returns {err, rdata} from the access rules: size from op, alignment, extension
   function automatic logic [32:0] model(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
      int size, b, h;
      bit ok;
      ok   = we ? (op <= 2) : (op <= 2 || op == 4 || op == 5);
      size = (op % 4 == 0) ? 1 : (op % 4 == 1) ? 2 : 4;
      if (!ok || (size > 1 && a % 2 == 1)) return {1'b1, 32'd0};
      if (we) return 33'd0;
      b = int'(((a % 2 == 1) ? rd >> 8 : rd) & 32'hFF);
      h = int'(rd & 32'hFFFF);
      case (op)
         3'd0:    return {1'b0, 32'(b >= 128 ? b - 256 : b)};
         3'd4:    return {1'b0, 32'(b)};
         3'd1:    return {1'b0, 32'(h >= 32768 ? h - 65536 : h)};
         3'd5:    return {1'b0, 32'(h)};
         default: return {1'b0, rd};
      endcase
   endfunction

   // responder: on EN_N low go busy after a random delay, then return READY with data
   initial begin
      forever begin
         @(negedge clk);
         if (!hold_ready && !EN_N && READY) begin
            bus_cnt++;
            seen_addr = address;
            seen_wlen = WLEN;
            seen_wdata = wdata;
            repeat ($urandom_range(2, 0)) @(negedge clk);
            READY = 0;
            repeat ($urandom_range(busy_hi, busy_lo)) @(negedge clk);
            if (reset_n && !req_ready) begin
               chk("hold_addr", address, seen_addr);
               chk("hold_wlen", 32'(WLEN), 32'(seen_wlen));
               chk("hold_wdata", wdata, seen_wdata);
            end
            rdata = rsp_data;
            READY = 1;
         end
      end
   end

   task automatic send(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
      int bnd = 0;
      while (!(req_ready && READY) && bnd < 100) begin
         @(negedge clk);
         bnd++;
      end
      chk("accept_wait", 32'(req_ready && READY), 32'd1);
      req_we = we;
      req_op = op;
      req_addr = a;
      req_wdata = wd;
      req_valid = 1;
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
      logic [32:0] m;
      int lat, c0;
      m = model(we, op, a, rd);
      rsp_data = rd;
      c0 = bus_cnt;
      send(we, op, a, wd);
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("resp_seen", 32'(resp_valid), 32'd1);
      chk("resp_err", 32'(resp_err), 32'(m[32]));
      chk("resp_rdata", resp_rdata, m[31:0]);
      chk("ready_in_resp", 32'(req_ready), 32'd0);
      chk("bus_cycles", 32'(bus_cnt - c0), m[32] ? 32'd0 : 32'd1);
      if (m[32]) chk("err_latency", 32'(lat), 32'd1);
      else begin
         chk("bus_addr", seen_addr, a);
         chk("bus_wdata", seen_wdata, wd);
         chk("bus_wlen", 32'(seen_wlen), !we ? 32'd0 : op == 0 ? 32'd1 : op == 1 ? 32'd2 : 32'd3);
      end
      @(negedge clk);
      chk("pulse_one", 32'(resp_valid), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_en_n", 32'(EN_N), 32'd1);
      chk("idle_wlen", 32'(WLEN), 32'd0);
   endtask

   initial begin
      int lat, cnt;
      #1 reset_n = 0;
      @(negedge clk);
      chk("rst_en_n", 32'(EN_N), 32'd1);
      chk("rst_wlen", 32'(WLEN), 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      reset_n = 1;
      do_req(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF);
      do_req(0, 3'b000, 32'h101, 32'h0, 32'h000080FF);
      do_req(0, 3'b100, 32'h101, 32'h0, 32'h000080FF);
      do_req(0, 3'b101, 32'h100, 32'h0, 32'h000080FF);
      do_req(0, 3'b001, 32'h102, 32'h0, 32'h00008001);
      do_req(1, 3'b000, 32'h80000, 32'h12345678, 32'hFFFFFFFF);
      do_req(1, 3'b010, 32'h103, 32'h1, 32'h0);
      do_req(0, 3'b011, 32'h100, 32'h0, 32'h1);
      do_req(1, 3'b100, 32'h100, 32'h0, 32'h1);
      do_req(0, 3'b001, 32'h101, 32'h0, 32'h1);
      for (int i = 0; i < 80; i++)
         do_req(1'($urandom), 3'($urandom_range(7, 0)), $urandom, $urandom, $urandom);
      hold_ready = 1;
      send(0, 3'b010, 32'h300, 32'h0);
`ifdef BUS_INIT_TIMEOUT_EN
      lat = 1;
      while (!resp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("to_latency", 32'(lat), 32'd9);
      chk("to_err", 32'(resp_err), 32'd1);
      chk("to_rdata", resp_rdata, 32'd0);
      chk("to_en_n", 32'(EN_N), 32'd1);
`else
      repeat (40) @(negedge clk);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_en_n", 32'(EN_N), 32'd0);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
`endif
      hold_ready = 0;
      busy_lo = 8;
      busy_hi = 8;
      send(0, 3'b010, 32'h200, 32'h0);
      cnt = 0;
      while (!(!READY && EN_N && !req_ready) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("reached_wait", 32'(!READY && EN_N && !req_ready), 32'd1);
      #2 reset_n = 0;
      #1;
      chk("arst_en_n", 32'(EN_N), 32'd1);
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset_n = 1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         cnt += int'(resp_valid);
      end
      chk("no_resp_after_rst", 32'(cnt), 32'd0);
      busy_lo = 1;
      busy_hi = 3;
      do_req(0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
